// File: rtl/lcu_pixel_streamer.sv
// lcu_pixel_streamer: streams a frame LCU by LCU (raster) from frame/param memories into the IPF core.
// Optional LPS_CHKSUM_EN adds a running 16-bit sum of transferred pixels on output chksum.
module lcu_pixel_streamer #(
    parameter int LCU_SIZE = 64,
    parameter int IMG_SIZE = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        busy,
    output logic        img_rd,
    output logic [13:0] img_addr,
    input  logic [7:0]  img_q,
    output logic        prm_rd,
    output logic [5:0]  prm_addr,
    input  logic [23:0] prm_q,
    output logic        in_en,
    output logic [7:0]  din,
    output logic [2:0]  lcu_x,
    output logic [2:0]  lcu_y,
    output logic [1:0]  ipf_type,
    output logic [4:0]  ipf_band_pos,
    output logic        ipf_wo_class,
    output logic [15:0] ipf_offset,
    output logic        done
`ifdef LPS_CHKSUM_EN
    ,
    output logic [15:0] chksum
`endif
);
    localparam int LOG_LCU = $clog2(LCU_SIZE);
    localparam int NLCU = IMG_SIZE / LCU_SIZE;
    localparam int NPIX = LCU_SIZE * LCU_SIZE;
    localparam int CW = 2 * LOG_LCU + 1;
    localparam logic [2:0] LAST = 3'(NLCU - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRM, S_PRM_W, S_STREAM, S_DONE} state_t;
    state_t r_state, w_next;

    logic [2:0]    r_nx, r_ny;
    logic [CW-1:0] r_rcnt, r_tcnt;
    logic [7:0]    r_f0, r_f1;
    logic [1:0]    r_cnt;
    logic          r_out;
    logic          w_xfer, w_pop, w_push, w_last_pix, w_last_lcu, w_room;
    logic [6:0]    w_ax, w_ay;

    always_comb begin
        w_room     = (r_cnt == 2'd0) || (r_cnt == 2'd1 && !r_out);
        img_rd     = (r_state == S_PRM_W || r_state == S_STREAM) && (r_rcnt < CW'(NPIX)) && w_room;
        w_ax       = 7'((int'(r_nx) << LOG_LCU) + int'(r_rcnt[LOG_LCU-1:0]));
        w_ay       = 7'((int'(r_ny) << LOG_LCU) + int'(r_rcnt[2*LOG_LCU-1:LOG_LCU]));
        img_addr   = {w_ay, w_ax};
        prm_rd     = r_state == S_PRM;
        prm_addr   = {r_ny, r_nx};
        done       = r_state == S_DONE;
        // Head of the skid FIFO, or the just-returned read word when the FIFO is empty
        in_en      = (r_cnt != 2'd0) || r_out;
        din        = (r_cnt != 2'd0) ? r_f0 : (r_out ? img_q : 8'd0);
        w_xfer     = in_en && !busy;
        w_pop      = w_xfer && (r_cnt != 2'd0);
        w_push     = r_out && !(r_cnt == 2'd0 && !busy);
        w_last_pix = w_xfer && (r_tcnt == CW'(NPIX - 1));
        w_last_lcu = (r_nx == LAST) && (r_ny == LAST);
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = start ? S_PRM : S_IDLE;
            S_PRM:    w_next = S_PRM_W;
            S_PRM_W:  w_next = S_STREAM;
            S_STREAM: if (w_last_pix) w_next = w_last_lcu ? S_DONE : S_PRM;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nx         <= '0;
            r_ny         <= '0;
            r_rcnt       <= '0;
            r_tcnt       <= '0;
            r_f0         <= '0;
            r_f1         <= '0;
            r_cnt        <= '0;
            r_out        <= 1'b0;
            lcu_x        <= '0;
            lcu_y        <= '0;
            ipf_type     <= '0;
            ipf_band_pos <= '0;
            ipf_wo_class <= 1'b0;
            ipf_offset   <= '0;
`ifdef LPS_CHKSUM_EN
            chksum       <= '0;
`endif
        end else begin
            r_out <= img_rd;
            r_cnt <= r_cnt + {1'b0, w_push} - {1'b0, w_pop};
            if (w_pop) r_f0 <= r_f1;
            if (w_push) begin
                if (r_cnt == 2'd0 || (r_cnt == 2'd1 && w_pop)) r_f0 <= img_q;
                else r_f1 <= img_q;
            end
            if (r_state == S_PRM) r_rcnt <= '0;
            else if (img_rd) r_rcnt <= r_rcnt + CW'(1);
            if (r_state == S_PRM) r_tcnt <= '0;
            else if (w_xfer) r_tcnt <= r_tcnt + CW'(1);
            if (r_state == S_PRM_W) begin
                lcu_x        <= r_nx;
                lcu_y        <= r_ny;
                ipf_type     <= prm_q[23:22];
                ipf_band_pos <= prm_q[21:17];
                ipf_wo_class <= prm_q[16];
                ipf_offset   <= prm_q[15:0];
            end
            if (w_last_pix) begin
                r_nx <= (r_nx == LAST) ? 3'd0 : r_nx + 3'd1;
                if (r_nx == LAST) r_ny <= (r_ny == LAST) ? 3'd0 : r_ny + 3'd1;
            end
`ifdef LPS_CHKSUM_EN
            if (r_state == S_IDLE && start) chksum <= '0;
            else if (w_xfer) chksum <= chksum + 16'(din);
`endif
        end
    end
endmodule

// File: tb/tb_lcu_pixel_streamer.sv
// tb_lcu_pixel_streamer: frame-level bench for lcu_pixel_streamer with memory models and a raster reference.
module tb_lcu_pixel_streamer;
    localparam int LCU = 64, IMG = 128, NL = 2, NPL = LCU * LCU, NPIX = IMG * IMG;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, busy = 1'b0;
    logic        img_rd, prm_rd, in_en, ipf_wo_class, done;
    logic [13:0] img_addr;
    logic [7:0]  img_q = '0, din;
    logic [5:0]  prm_addr;
    logic [23:0] prm_q = '0;
    logic [2:0]  lcu_x, lcu_y;
    logic [1:0]  ipf_type;
    logic [4:0]  ipf_band_pos;
    logic [15:0] ipf_offset;
`ifdef LPS_CHKSUM_EN
    logic [15:0] chksum, done_chk;
`endif

    lcu_pixel_streamer #(.LCU_SIZE(LCU), .IMG_SIZE(IMG)) dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .img_rd(img_rd), .img_addr(img_addr), .img_q(img_q),
        .prm_rd(prm_rd), .prm_addr(prm_addr), .prm_q(prm_q),
        .in_en(in_en), .din(din), .lcu_x(lcu_x), .lcu_y(lcu_y),
        .ipf_type(ipf_type), .ipf_band_pos(ipf_band_pos), .ipf_wo_class(ipf_wo_class),
        .ipf_offset(ipf_offset), .done(done)
`ifdef LPS_CHKSUM_EN
        , .chksum(chksum)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0]  img_mem [NPIX];
    logic [23:0] prm_mem [64];

    always @(posedge clk) begin
        if (img_rd) img_q <= img_mem[img_addr];
        if (prm_rd) prm_q <= prm_mem[prm_addr];
    end

    logic [37:0] cap_obs [NPIX];
    int          cap_cyc [NPIX];
    int ncap, cyc, mode, hold, done_cnt, done_cyc, prm_cnt, first_prm, first_img, first_in, stab_err;
    int ntests, nfail;
    logic [13:0] first_img_addr;
    logic        prev_stall;
    logic [37:0] saved;

    typedef struct {
        int          idx;
        logic [7:0]  din;
        logic [2:0]  lx, ly;
        logic [15:0] off;
    } probe_t;
    probe_t pt [8];

    function automatic logic [37:0] obs();
        return {din, lcu_x, lcu_y, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset};
    endfunction

    // Reference: pixel i of the stream in LCU-raster / pixel-raster order
    function automatic logic [37:0] exp_px(int i);
        int k, lx, ly, p, addr;
        k = i / NPL; lx = k % NL; ly = k / NL; p = i % NPL;
        addr = (ly * LCU + p / LCU) * IMG + lx * LCU + p % LCU;
        return {img_mem[addr], 3'(lx), 3'(ly), prm_mem[ly * 8 + lx]};
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        #1;
        start = 1'b0;
        case (mode)
            0: busy = 1'b0;
            1: busy = 1'($urandom_range(0, 1));
            default: begin
                busy = (ncap == NPIX - 1) && (hold < 10);
                if (busy) hold++;
            end
        endcase
        @(negedge clk);
        if (prev_stall && (!in_en || obs() !== saved)) stab_err++;
        prev_stall = in_en && busy;
        saved = obs();
        if (prm_rd) begin prm_cnt++; if (first_prm < 0) first_prm = cyc; end
        if (img_rd && first_img < 0) begin first_img = cyc; first_img_addr = img_addr; end
        if (in_en && first_in < 0) first_in = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
`ifdef LPS_CHKSUM_EN
            done_chk = chksum;
`endif
        end
        if (in_en && !busy && ncap < NPIX) begin
            cap_obs[ncap] = obs();
            cap_cyc[ncap] = cyc;
            ncap++;
        end
    endtask

    task automatic run_frame(input int m, input int stop_at, input bit collide, output int s);
        bit mid, ok;
        mid = 0; ok = 0;
        ncap = 0; hold = 0; done_cnt = 0; prm_cnt = 0; stab_err = 0; prev_stall = 0;
        first_prm = -1; first_img = -1; first_in = -1; done_cyc = -1;
        mode = m; start = 1'b1; s = cyc;
        for (int n = 0; n < 70000 && !ok; n++) begin
            step();
            if (collide && !mid && ncap == 2000) begin start = 1'b1; mid = 1; end
            if (collide && cyc == s + 3 + NPIX + 2 * (NL * NL - 1)) start = 1'b1;
            ok = done_cnt > 0 || ncap >= stop_at;
        end
        chk("frame_end", 64'(ok), 64'd1);
        if (done_cnt > 0) repeat (5) step();
    endtask

    task automatic check_seq(input string nm);
        int bad;
        bad = -1;
        for (int i = 0; i < NPIX && bad < 0; i++) if (cap_obs[i] !== exp_px(i)) bad = i;
        ntests++;
        if (bad >= 0) begin
            nfail++;
            $display("FAIL %s: pixel %0d got %h expected %h", nm, bad, cap_obs[bad], exp_px(bad));
        end
    endtask

    initial begin
        int s, gbad;
        ntests = 0; nfail = 0; cyc = 0; mode = 0; ncap = 0; hold = 0; prev_stall = 0;
        pt[0] = '{0,     8'h00, 3'd0, 3'd0, 16'h0000};
        pt[1] = '{1,     8'h01, 3'd0, 3'd0, 16'h0000};
        pt[2] = '{64,    8'h80, 3'd0, 3'd0, 16'h0000};
        pt[3] = '{4095,  8'hBF, 3'd0, 3'd0, 16'h0000};
        pt[4] = '{4096,  8'h40, 3'd1, 3'd0, 16'h0001};
        pt[5] = '{8192,  8'h00, 3'd0, 3'd1, 16'h0002};
        pt[6] = '{12288, 8'h40, 3'd1, 3'd1, 16'h0003};
        pt[7] = '{16383, 8'hFF, 3'd1, 3'd1, 16'h0003};

        // Frame A: ramp image, prm entry for the k-th LCU = A5_0000+k, no back-pressure
        for (int i = 0; i < NPIX; i++) img_mem[i] = 8'(i);
        for (int i = 0; i < 64; i++) prm_mem[i] = '0;
        for (int y = 0; y < NL; y++)
            for (int x = 0; x < NL; x++) prm_mem[y * 8 + x] = 24'hA50000 + 24'(y * NL + x);

        repeat (3) step();
        chk("rst_stream", {in_en, din, done}, '0);
        chk("rst_addr", {img_rd, img_addr, prm_rd, prm_addr}, '0);
        chk("rst_side", {lcu_x, lcu_y, ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset}, '0);
`ifdef LPS_CHKSUM_EN
        chk("rst_chksum", chksum, '0);
`endif
        reset = 1'b0;
        step();

        run_frame(0, NPIX + 1, 1'b1, s);
        chk("A_prm_lat", first_prm, s + 1);
        chk("A_img_lat", first_img, s + 2);
        chk("A_in_lat", first_in, s + 3);
        chk("A_count", ncap, NPIX);
        for (int v = 0; v < 8; v++)
            chk($sformatf("A_probe%0d", pt[v].idx),
                {cap_obs[pt[v].idx][37:24], cap_obs[pt[v].idx][15:0]},
                {pt[v].din, pt[v].lx, pt[v].ly, pt[v].off});
        check_seq("A_seq");
        gbad = 0;
        for (int i = 0; i < NPIX; i++) if (cap_cyc[i] != s + 3 + i + 2 * (i / NPL)) gbad++;
        chk("A_gaps", gbad, 0);
        chk("A_done_cyc", done_cyc, cap_cyc[NPIX-1] + 1);
        chk("A_done_cnt", done_cnt, 1);
        chk("A_prm_reads", prm_cnt, NL * NL);

        // Frame B: random image and parameters, 50% random back-pressure
        for (int i = 0; i < NPIX; i++) img_mem[i] = 8'($urandom);
        for (int i = 0; i < 64; i++) prm_mem[i] = 24'($urandom);
        run_frame(1, NPIX + 1, 1'b0, s);
        chk("B_count", ncap, NPIX);
        check_seq("B_seq");
        chk("B_stable", stab_err, 0);
        chk("B_done_cyc", done_cyc, cap_cyc[NPIX-1] + 1);
        chk("B_done_cnt", done_cnt, 1);

        // Frame C aborted by reset at pixel 5000, then frame D with the last pixel held off
        for (int i = 0; i < NPIX; i++) img_mem[i] = 8'($urandom);
        img_mem[0] = 8'h5A;
        run_frame(0, 5000, 1'b0, s);
        reset = 1'b1;
        #1;
        chk("C_rst_mid", {in_en, din, img_rd, prm_rd, img_addr, prm_addr, lcu_x, lcu_y,
                          ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset, done}, '0);
        repeat (2) step();
        reset = 1'b0;
        step();
        run_frame(2, NPIX + 1, 1'b0, s);
        chk("D_count", ncap, NPIX);
        chk("D_first_addr", first_img_addr, 14'd0);
        chk("D_first_din", cap_obs[0][37:30], 8'h5A);
        check_seq("D_seq");
        chk("D_last_stall", cap_cyc[NPIX-1] - cap_cyc[NPIX-2], 11);
        chk("D_done_cyc", done_cyc, cap_cyc[NPIX-1] + 1);
        chk("D_done_cnt", done_cnt, 1);
        chk("D_stable", stab_err, 0);

`ifdef LPS_CHKSUM_EN
        for (int i = 0; i < NPIX; i++) img_mem[i] = 8'hFF;
        run_frame(0, NPIX + 1, 1'b0, s);
        chk("E_chksum", done_chk, 16'hC000);
`endif

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
